// File: rtl/axi_burst_beat_gen.sv
// Expands one AXI4 AR/AW request into a stream of per-beat address, lane-mask,
// index, last and error information for the data-channel logic.
module axi_burst_beat_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ax_valid_i,
    output logic                    ax_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ax_addr_i,
    input  logic [LEN_WIDTH-1:0]    ax_len_i,
    input  logic [2:0]              ax_size_i,
    input  logic [1:0]              ax_burst_i,
    input  logic [ID_WIDTH-1:0]     ax_id_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [ADDR_WIDTH-1:0]   beat_addr_o,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o,
    output logic [LEN_WIDTH-1:0]    beat_idx_o,
    output logic                    beat_last_o,
    output logic [ID_WIDTH-1:0]     beat_id_o,
    output logic                    beat_err_o
);

    localparam int DB     = DATA_WIDTH / 8;
    localparam int LOG_DB = $clog2(DB);
    localparam int AW1    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] DB_MASK = ADDR_WIDTH'(DB - 1);

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;
    localparam logic [1:0] B_RSVD  = 2'b11;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                  r_state;
    logic                    r_beat_valid;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DB-1:0]           r_strb;
    logic [LEN_WIDTH-1:0]    r_idx;
    logic                    r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic                    r_err;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [ADDR_WIDTH-1:0]   r_wbase;
    logic [AW1-1:0]          r_wend;

    // Lanes from the byte address up to the top of the N-aligned container.
    function automatic logic [DB-1:0] f_strb(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [2:0] sz);
        logic [DB-1:0] s;
        int n;
        int lo;
        int hi;
        n  = 1 << sz;
        lo = int'(a & DB_MASK);
        hi = int'((a & ~ADDR_WIDTH'(n - 1)) & DB_MASK) + n - 1;
        s  = '0;
        for (int i = 0; i < DB; i++) begin
            s[i] = (i >= lo) && (i <= hi);
        end
        return s;
    endfunction

    logic [AW1-1:0]  w_a0_x;
    logic [AW1-1:0]  w_n_in;
    logic [AW1-1:0]  w_t_in;
    logic [AW1-1:0]  w_base_in;
    logic [AW1-1:0]  w_wend_in;
    logic [11:0]     w_aal_lo;
    logic [31:0]     w_4k_sum;
    logic            w_wrap_len_ok;
    logic            w_err_in;

    assign w_a0_x    = {1'b0, ax_addr_i};
    assign w_n_in    = AW1'(1) << ax_size_i;
    assign w_t_in    = (AW1'(ax_len_i) + AW1'(1)) << ax_size_i;
    assign w_base_in = w_a0_x & ~(w_t_in - AW1'(1));
    assign w_wend_in = w_base_in + w_t_in;
    assign w_aal_lo  = ax_addr_i[11:0] & ~((12'd1 << ax_size_i) - 12'd1);
    assign w_4k_sum  = 32'(w_aal_lo) + ((32'(ax_len_i) + 32'd1) << ax_size_i);

    assign w_wrap_len_ok = (ax_len_i == LEN_WIDTH'(1)) || (ax_len_i == LEN_WIDTH'(3)) ||
                           (ax_len_i == LEN_WIDTH'(7)) || (ax_len_i == LEN_WIDTH'(15));

    assign w_err_in = (int'(ax_size_i) > LOG_DB)
                   || (ax_burst_i == B_RSVD)
                   || ((ax_burst_i == B_WRAP) && !w_wrap_len_ok)
                   || ((ax_burst_i == B_WRAP) && ((w_a0_x & (w_n_in - AW1'(1))) != '0))
                   || ((ax_burst_i == B_FIXED) && (ax_len_i > LEN_WIDTH'(15)))
                   || ((ax_burst_i == B_INCR) && (w_4k_sum > 32'd4096));

    logic [AW1-1:0]        w_n_cur;
    logic [AW1-1:0]        w_cur_al;
    logic [AW1-1:0]        w_wrap_sum;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [LEN_WIDTH-1:0]  w_idx_nxt;

    assign w_n_cur    = AW1'(1) << r_size;
    assign w_cur_al   = {1'b0, r_addr} & ~(w_n_cur - AW1'(1));
    assign w_wrap_sum = {1'b0, r_addr} + w_n_cur;
    assign w_idx_nxt  = r_idx + LEN_WIDTH'(1);

    always_comb begin
        w_next_addr = ADDR_WIDTH'(w_cur_al + w_n_cur);
        case (r_burst)
            B_FIXED: w_next_addr = r_addr;
            B_WRAP:  w_next_addr = (w_wrap_sum == r_wend) ? r_wbase : ADDR_WIDTH'(w_wrap_sum);
            default: w_next_addr = ADDR_WIDTH'(w_cur_al + w_n_cur);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_beat_valid <= 1'b0;
            r_addr       <= '0;
            r_strb       <= '0;
            r_idx        <= '0;
            r_last       <= 1'b0;
            r_id         <= '0;
            r_err        <= 1'b0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_wbase      <= '0;
            r_wend       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ax_valid_i) begin
                        r_state      <= S_BURST;
                        r_beat_valid <= 1'b1;
                        r_addr       <= ax_addr_i;
                        r_strb       <= f_strb(ax_addr_i, ax_size_i);
                        r_idx        <= '0;
                        r_last       <= (ax_len_i == '0);
                        r_id         <= ax_id_i;
                        r_err        <= w_err_in;
                        r_len        <= ax_len_i;
                        r_size       <= ax_size_i;
                        r_burst      <= ax_burst_i;
                        r_wbase      <= ADDR_WIDTH'(w_base_in);
                        r_wend       <= w_wend_in;
                    end
                end
                S_BURST: begin
                    if (beat_ready_i) begin
                        if (r_last) begin
                            r_state      <= S_IDLE;
                            r_beat_valid <= 1'b0;
                            r_last       <= 1'b0;
                        end else begin
                            r_addr <= w_next_addr;
                            r_strb <= f_strb(w_next_addr, r_size);
                            r_idx  <= w_idx_nxt;
                            r_last <= (w_idx_nxt == r_len);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ax_ready_o   = (r_state == S_IDLE) && !rst_i;
    assign beat_valid_o = r_beat_valid;
    assign beat_addr_o  = r_addr;
    assign beat_strb_o  = r_strb;
    assign beat_idx_o   = r_idx;
    assign beat_last_o  = r_last;
    assign beat_id_o    = r_id;
    assign beat_err_o   = r_err;

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Bench for axi_burst_beat_gen: directed beat table, hand-written stall and
// reset sequences, and randomized requests against a burst-level reference model.
module tb_axi_burst_beat_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ax_valid_i = 1'b0;
    logic        ax_ready_o;
    logic [31:0] ax_addr_i = '0;
    logic [7:0]  ax_len_i = '0;
    logic [2:0]  ax_size_i = '0;
    logic [1:0]  ax_burst_i = '0;
    logic [3:0]  ax_id_i = '0;
    logic        beat_valid_o;
    logic        beat_ready_i = 1'b0;
    logic [31:0] beat_addr_o;
    logic [7:0]  beat_strb_o;
    logic [7:0]  beat_idx_o;
    logic        beat_last_o;
    logic [3:0]  beat_id_o;
    logic        beat_err_o;

    axi_burst_beat_gen #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .LEN_WIDTH(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ax_valid_i(ax_valid_i), .ax_ready_o(ax_ready_o),
        .ax_addr_i(ax_addr_i), .ax_len_i(ax_len_i), .ax_size_i(ax_size_i),
        .ax_burst_i(ax_burst_i), .ax_id_i(ax_id_i),
        .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
        .beat_addr_o(beat_addr_o), .beat_strb_o(beat_strb_o), .beat_idx_o(beat_idx_o),
        .beat_last_o(beat_last_o), .beat_id_o(beat_id_o), .beat_err_o(beat_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [7:0]  idx;
        logic        last;
        logic [3:0]  id;
        logic        err;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          size;
        int          burst;
        int          id;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          size;
        int          burst;
        int          id;
        beat_t       exp;
    } vec_t;

    int    n_pass  = 0;
    int    n_total = 0;
    beat_t exp_q[$];
    vec_t  tbl[17];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic beat_t mkb(input logic [31:0] a, input logic [7:0] s, input int i,
                                  input bit l, input int id, input bit e);
        beat_t b;
        b.addr = a; b.strb = s; b.idx = 8'(i); b.last = l; b.id = 4'(id); b.err = e;
        return b;
    endfunction

    function automatic beat_t cur_beat();
        beat_t b;
        b.addr = beat_addr_o; b.strb = beat_strb_o; b.idx = beat_idx_o;
        b.last = beat_last_o; b.id = beat_id_o; b.err = beat_err_o;
        return b;
    endfunction

    // Reference: list every beat of the burst straight from the address/strobe/error rules.
    task automatic build_exp(input req_t r);
        longint n, a0, aal, t, base, wend, cur, nx, lo, hi;
        longint mask;
        bit     err;
        logic [7:0] s;
        mask = 64'hFFFF_FFFF;
        n    = longint'(1) << r.size;
        a0   = longint'(r.addr);
        aal  = a0 & ~(n - 1);
        t    = n * (r.len + 1);
        base = a0 & ~(t - 1);
        wend = base + t;
        err  = (n > 8) || (r.burst == 3)
            || (r.burst == 2 && !(r.len == 1 || r.len == 3 || r.len == 7 || r.len == 15))
            || (r.burst == 2 && (a0 % n) != 0)
            || (r.burst == 0 && r.len > 15)
            || (r.burst == 1 && (aal % 4096) + t > 4096);
        exp_q.delete();
        cur = a0;
        for (int i = 0; i <= r.len; i++) begin
            lo = cur % 8;
            hi = ((cur & ~(n - 1)) % 8) + n - 1;
            for (int l = 0; l < 8; l++) s[l] = (l >= lo) && (l <= hi);
            exp_q.push_back(mkb(32'(cur), s, i, i == r.len, r.id, err));
            if (r.burst == 0) cur = a0;
            else if (r.burst == 2) begin
                nx = cur + n;
                if (nx == wend) nx = base;
                cur = nx & mask;
            end else cur = (aal + longint'(i + 1) * n) & mask;
        end
    endtask

    // Issue one request and check every beat against exp_q.
    task automatic run_exp(input req_t r, input bit rnd_stall, input int hold_at);
        int waits;
        @(negedge clk_i);
        ax_valid_i = 1'b1;
        ax_addr_i  = r.addr;
        ax_len_i   = 8'(r.len);
        ax_size_i  = 3'(r.size);
        ax_burst_i = 2'(r.burst);
        ax_id_i    = 4'(r.id);
        chk("ax_ready_idle", 64'(ax_ready_o), 64'(1));
        @(negedge clk_i);
        ax_valid_i = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == hold_at) begin
                for (int c = 0; c < 5; c++) begin
                    beat_ready_i = 1'b0;
                    chk($sformatf("hold_beat%0d_cyc%0d", k, c),
                        64'({ax_ready_o, beat_valid_o, cur_beat()}), 64'({1'b0, 1'b1, exp_q[k]}));
                    @(negedge clk_i);
                end
            end
            if (rnd_stall) begin
                waits = 0;
                while ($urandom_range(0, 2) == 0 && waits < 20) begin
                    beat_ready_i = 1'b0;
                    @(negedge clk_i);
                    waits++;
                end
            end
            chk($sformatf("beat%0d", k),
                64'({ax_ready_o, beat_valid_o, cur_beat()}), 64'({1'b0, 1'b1, exp_q[k]}));
            beat_ready_i = 1'b1;
            @(negedge clk_i);
        end
        beat_ready_i = 1'b0;
        chk("gap_valid_ready", 64'({beat_valid_o, ax_ready_o}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        req_t r;
        int   i;

        tbl[0]  = '{32'h1002, 3, 2, 1, 4'hA, mkb(32'h1002, 8'h0C, 0, 0, 4'hA, 0)};
        tbl[1]  = '{32'h1002, 3, 2, 1, 4'hA, mkb(32'h1004, 8'hF0, 1, 0, 4'hA, 0)};
        tbl[2]  = '{32'h1002, 3, 2, 1, 4'hA, mkb(32'h1008, 8'h0F, 2, 0, 4'hA, 0)};
        tbl[3]  = '{32'h1002, 3, 2, 1, 4'hA, mkb(32'h100C, 8'hF0, 3, 1, 4'hA, 0)};
        tbl[4]  = '{32'h1010, 3, 3, 2, 4'h1, mkb(32'h1010, 8'hFF, 0, 0, 4'h1, 0)};
        tbl[5]  = '{32'h1010, 3, 3, 2, 4'h1, mkb(32'h1018, 8'hFF, 1, 0, 4'h1, 0)};
        tbl[6]  = '{32'h1010, 3, 3, 2, 4'h1, mkb(32'h1000, 8'hFF, 2, 0, 4'h1, 0)};
        tbl[7]  = '{32'h1010, 3, 3, 2, 4'h1, mkb(32'h1008, 8'hFF, 3, 1, 4'h1, 0)};
        tbl[8]  = '{32'h0020, 2, 1, 0, 4'h5, mkb(32'h0020, 8'h03, 0, 0, 4'h5, 0)};
        tbl[9]  = '{32'h0020, 2, 1, 0, 4'h5, mkb(32'h0020, 8'h03, 1, 0, 4'h5, 0)};
        tbl[10] = '{32'h0020, 2, 1, 0, 4'h5, mkb(32'h0020, 8'h03, 2, 1, 4'h5, 0)};
        tbl[11] = '{32'h0FF8, 1, 3, 1, 4'h7, mkb(32'h0FF8, 8'hFF, 0, 0, 4'h7, 1)};
        tbl[12] = '{32'h0FF8, 1, 3, 1, 4'h7, mkb(32'h1000, 8'hFF, 1, 1, 4'h7, 1)};
        tbl[13] = '{32'h0000, 0, 4, 1, 4'h2, mkb(32'h0000, 8'hFF, 0, 1, 4'h2, 1)};
        tbl[14] = '{32'h0040, 2, 3, 2, 4'hF, mkb(32'h0040, 8'hFF, 0, 0, 4'hF, 1)};
        tbl[15] = '{32'h0040, 2, 3, 2, 4'hF, mkb(32'h0048, 8'hFF, 1, 0, 4'hF, 1)};
        tbl[16] = '{32'h0040, 2, 3, 2, 4'hF, mkb(32'h0050, 8'hFF, 2, 1, 4'hF, 1)};

        #1;
        chk("rst_ax_ready", 64'(ax_ready_o), 64'(0));
        chk("rst_outputs", 64'({beat_valid_o, cur_beat()}), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ax_ready", 64'(ax_ready_o), 64'(1));

        i = 0;
        while (i < 17) begin
            r = '{tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].id};
            exp_q.delete();
            for (int k = 0; k <= r.len; k++) exp_q.push_back(tbl[i + k].exp);
            run_exp(r, 1'b0, -1);
            i += r.len + 1;
        end

        r = '{32'h2000, 5, 2, 1, 3};
        build_exp(r);
        run_exp(r, 1'b0, 2);

        r = '{32'h0300, 3, 3, 1, 2};
        @(negedge clk_i);
        ax_valid_i = 1'b1; ax_addr_i = r.addr; ax_len_i = 8'(r.len);
        ax_size_i = 3'(r.size); ax_burst_i = 2'(r.burst); ax_id_i = 4'(r.id);
        @(negedge clk_i);
        ax_valid_i   = 1'b0;
        beat_ready_i = 1'b1;
        @(negedge clk_i);
        beat_ready_i = 1'b0;
        chk("pre_rst_beat1", 64'({beat_valid_o, beat_idx_o, beat_addr_o}), 64'({1'b1, 8'd1, 32'h0308}));
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_valid_ready", 64'({beat_valid_o, ax_ready_o}), 64'(0));
        chk("midrst_outputs", 64'(cur_beat()), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("after_rst_ax_ready", 64'(ax_ready_o), 64'(1));
        r = '{32'h0500, 3, 2, 1, 9};
        build_exp(r);
        run_exp(r, 1'b0, -1);

        for (int it = 0; it < 150; it++) begin
            r.size  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            r.burst = int'($urandom_range(0, 3));
            r.len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 15));
            r.id    = int'($urandom_range(0, 15));
            r.addr  = $urandom;
            if ($urandom_range(0, 2) == 0) r.addr[11:0] = 12'hF80 | 12'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
            build_exp(r);
            run_exp(r, 1'b1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
